alu_mult_seq: RTL and testbench

//   Sequencer that reuses the shared 4-bit ALU as the adder of an unsigned

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_mult_seq_if.sv | 24 ++
 rtl/FourBitALU.sv | 38 +++
 rtl/alu_mult_seq.sv | 115 +++++++++++
 tb/tb_alu_mult_seq.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU and the shift-add multiply sequencer:
// ALU width, ALU op codes and the sequencer state encoding.
package alu_pkg;

    localparam int ALU_WIDTH = 4;

    localparam logic [2:0] ALU_OP_AND = 3'b000;
    localparam logic [2:0] ALU_OP_OR  = 3'b001;
    localparam logic [2:0] ALU_OP_ADD = 3'b010;
    localparam logic [2:0] ALU_OP_SUB = 3'b110;
    localparam logic [2:0] ALU_OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } mult_state_e;

endpackage

// File: rtl/alu_mult_seq_if.sv
// Command/product handshake bundle of the multiply sequencer.
// master = command issuer / product consumer, slave = the sequencer.
interface alu_mult_seq_if #(
    parameter int WIDTH = 4
);
    logic               start_valid;
    logic               start_ready;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic               res_valid;
    logic               res_ready;
    logic [2*WIDTH-1:0] product;
    logic               busy;

    modport master (
        output start_valid, mcand, mplier, res_ready,
        input  start_ready, res_valid, product, busy
    );

    modport slave (
        input  start_valid, mcand, mplier, res_ready,
        output start_ready, res_valid, product, busy
    );
endinterface

// File: rtl/FourBitALU.sv
// Shared 4-bit combinational ALU. Only result/cout are modelled; the
// multiply sequencer uses it purely as an adder.
module FourBitALU
    import alu_pkg::*;
(
    input  logic [ALU_WIDTH-1:0] a,
    input  logic [ALU_WIDTH-1:0] b,
    input  logic [2:0]           op,
    output logic [ALU_WIDTH-1:0] result,
    output logic                 cout
);

    logic [ALU_WIDTH:0] sum;
    logic [ALU_WIDTH:0] diff;

    // Operation select; subtract is a + ~b + 1 so cout is the no-borrow flag.
    always_comb begin
        sum    = {1'b0, a} + {1'b0, b};
        diff   = {1'b0, a} + {1'b0, ~b} + {{ALU_WIDTH{1'b0}}, 1'b1};
        result = '0;
        cout   = 1'b0;
        case (op)
            ALU_OP_AND: result = a & b;
            ALU_OP_OR:  result = a | b;
            ALU_OP_ADD: begin
                result = sum[ALU_WIDTH-1:0];
                cout   = sum[ALU_WIDTH];
            end
            ALU_OP_SUB: begin
                result = diff[ALU_WIDTH-1:0];
                cout   = diff[ALU_WIDTH];
            end
            ALU_OP_SLT: result = {{(ALU_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default:    result = '0;
        endcase
    end

endmodule

// File: rtl/alu_mult_seq.sv
// Unsigned shift-add multiplier sequencer that borrows the external 4-bit
// ALU as its adder. Product = {acc, q} after WIDTH iterations.
// Optional macro MULT_SEQ_ZERO_BYPASS_EN: a zero operand skips the RUN
// iterations and goes straight to DONE with a zero product.
module alu_mult_seq
    import alu_pkg::*;
#(
    parameter int         WIDTH  = ALU_WIDTH,
    parameter logic [2:0] ADD_OP = ALU_OP_ADD
) (
    input  logic             clk,
    input  logic             rst,
    alu_mult_seq_if.slave    bus,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_cout
);

    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

    mult_state_e      state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             start_ready_q, start_ready_d;
    logic             res_valid_q, res_valid_d;
    logic             busy_q, busy_d;
    logic             accept;

    // Next-state, datapath iteration and registered-output decode.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        q_d     = q_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        accept  = bus.start_valid && start_ready_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    m_d     = bus.mcand;
                    q_d     = bus.mplier;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
`ifdef MULT_SEQ_ZERO_BYPASS_EN
                    if (bus.mcand == '0 || bus.mplier == '0) begin
                        q_d     = '0;
                        state_d = DONE;
                    end
`endif
                end
            end
            RUN: begin
                // 5-bit {cout,sum} shifts right by one into {acc,q}.
                if (q_q[0]) begin
                    {acc_d, q_d} = {alu_cout, alu_result, q_q[WIDTH-1:1]};
                end else begin
                    {acc_d, q_d} = {1'b0, acc_q, q_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        start_ready_d = (state_d == IDLE);
        busy_d        = (state_d == RUN);
        res_valid_d   = (state_d == DONE);
    end

    // State, datapath and handshake flags with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            acc_q         <= '0;
            q_q           <= '0;
            m_q           <= '0;
            cnt_q         <= '0;
            start_ready_q <= 1'b1;
            res_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            q_q           <= q_d;
            m_q           <= m_d;
            cnt_q         <= cnt_d;
            start_ready_q <= start_ready_d;
            res_valid_q   <= res_valid_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.start_ready = start_ready_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.busy        = busy_q;
    assign bus.product     = {acc_q, q_q};
    assign alu_a           = acc_q;
    assign alu_b           = m_q;
    assign alu_op          = ADD_OP;

endmodule

// File: tb/tb_alu_mult_seq.sv
// Bench for alu_mult_seq wired to FourBitALU. A transaction-level model
// (product = a*b, fixed latency) drives a per-cycle compare process;
// directed scenarios add literal expectations.
module tb_alu_mult_seq;
    import alu_pkg::*;

`ifdef MULT_SEQ_ZERO_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif
    // Rising edges after the accept edge until res_valid is seen.
    localparam int LAT_FULL = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] alu_a, alu_b, alu_result;
    logic [2:0] alu_op;
    logic       alu_cout;

    always #5 clk = ~clk;

    alu_mult_seq_if #(.WIDTH(4)) bus ();

    alu_mult_seq #(.WIDTH(4), .ADD_OP(3'b010)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_cout   (alu_cout)
    );

    FourBitALU alu (
        .a      (alu_a),
        .b      (alu_b),
        .op     (alu_op),
        .result (alu_result),
        .cout   (alu_cout)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_lat(input logic [3:0] a, input logic [3:0] b);
        return (BYPASS && (a == 4'd0 || b == 4'd0)) ? 0 : LAT_FULL;
    endfunction

    // Transaction model: one outstanding product, visible after a fixed edge count.
    bit         m_started   = 1'b0;
    bit         m_inflight  = 1'b0;
    bit         m_post_rst  = 1'b0;
    int         m_ecount    = 0;
    int         m_done_edge = 0;
    logic [7:0] m_prod      = '0;
    logic [3:0] m_mcand     = '0;

    always @(posedge clk) begin
        m_ecount <= m_ecount + 1;
        if (rst) begin
            m_started  <= 1'b1;
            m_inflight <= 1'b0;
            m_post_rst <= 1'b1;
        end else if (!m_inflight) begin
            if (bus.start_valid) begin
                m_inflight  <= 1'b1;
                m_done_edge <= m_ecount + 1 + exp_lat(bus.mcand, bus.mplier);
                m_prod      <= 8'(bus.mcand * bus.mplier);
                m_mcand     <= bus.mcand;
                m_post_rst  <= 1'b0;
            end
        end else if (m_ecount >= m_done_edge && bus.res_ready) begin
            m_inflight <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (m_started && !rst) begin
            chk("alu_op", alu_op, 3'b010);
            if (!m_inflight) begin
                chk("idle_start_ready", bus.start_ready, 1);
                chk("idle_res_valid", bus.res_valid, 0);
                chk("idle_busy", bus.busy, 0);
                if (m_post_rst) begin
                    chk("rst_product", bus.product, 0);
                    chk("rst_alu_a", alu_a, 0);
                    chk("rst_alu_b", alu_b, 0);
                end
            end else if (m_ecount < m_done_edge) begin
                chk("run_start_ready", bus.start_ready, 0);
                chk("run_res_valid", bus.res_valid, 0);
                chk("run_busy", bus.busy, 1);
                chk("run_alu_b", alu_b, m_mcand);
            end else begin
                chk("done_start_ready", bus.start_ready, 0);
                chk("done_res_valid", bus.res_valid, 1);
                chk("done_busy", bus.busy, 0);
                chk("done_product", bus.product, m_prod);
                chk("done_alu_b", alu_b, m_mcand);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one command; returns edges from accept edge to res_valid.
    task automatic issue(input logic [3:0] a, input logic [3:0] b, output int lat);
        int n = 0;
        while (!bus.start_ready && n < 20) begin
            tick();
            n++;
        end
        if (!bus.start_ready) chk("start_ready_timeout", 0, 1);
        bus.start_valid = 1'b1;
        bus.mcand       = a;
        bus.mplier      = b;
        tick();
        bus.start_valid = 1'b0;
        lat = 0;
        while (!bus.res_valid && lat < 20) begin
            tick();
            lat++;
        end
        if (!bus.res_valid) chk("res_valid_timeout", 0, 1);
    endtask

    task automatic run_mult(input string name, input logic [3:0] a, input logic [3:0] b,
                            input logic [7:0] prod, input int lat_exp);
        int lat;
        issue(a, b, lat);
        chk({name, "_product"}, bus.product, prod);
        chk({name, "_latency"}, lat, lat_exp);
        tick();
    endtask

    initial begin
        int lat;
        rst             = 1'b1;
        bus.start_valid = 1'b0;
        bus.mcand       = '0;
        bus.mplier      = '0;
        bus.res_ready   = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        chk("reset_product", bus.product, 8'h00);
        chk("reset_start_ready", bus.start_ready, 1);
        chk("reset_res_valid", bus.res_valid, 0);
        tick();

        run_mult("m13x9", 4'd13, 4'd9, 8'h75, 4);
        run_mult("m15x15", 4'd15, 4'd15, 8'hE1, 4);
        run_mult("m0x7", 4'd0, 4'd7, 8'h00, BYPASS ? 0 : 4);

        // Product held under back-pressure; stray commands ignored.
        bus.res_ready = 1'b0;
        issue(4'd6, 4'd5, lat);
        chk("m6x5_product", bus.product, 8'h1E);
        for (int i = 0; i < 3; i++) begin
            bus.start_valid = 1'b1;
            bus.mcand       = 4'd9;
            bus.mplier      = 4'd9;
            tick();
            chk("hold_product", bus.product, 8'h1E);
            chk("hold_start_ready", bus.start_ready, 0);
            chk("hold_res_valid", bus.res_valid, 1);
        end
        bus.start_valid = 1'b0;
        bus.res_ready   = 1'b1;
        tick();
        chk("b2b_start_ready", bus.start_ready, 1);
        run_mult("m2x3", 4'd2, 4'd3, 8'h06, 4);

        // Reset during the second RUN cycle of 11*11.
        bus.start_valid = 1'b1;
        bus.mcand       = 4'd11;
        bus.mplier      = 4'd11;
        tick();
        bus.start_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_product", bus.product, 8'h00);
        chk("abort_start_ready", bus.start_ready, 1);
        chk("abort_busy", bus.busy, 0);
        chk("abort_res_valid", bus.res_valid, 0);
        chk("abort_alu_a", alu_a, 0);
        chk("abort_alu_b", alu_b, 0);
        run_mult("m3x4", 4'd3, 4'd4, 8'h0C, 4);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_mult("exh", 4'(a), 4'(b), 8'(a * b), exp_lat(4'(a), 4'(b)));
            end
        end

        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
